// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the 4-way bus arbiter.
//   NUM_REQ      : number of requesters (fixed at 4)
//   arb_state_e  : IDLE/BUSY state encoding
//   arb_idx_t    : 2-bit requester index
//   idx2onehot() : index -> one-hot grant vector
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef logic [1:0] arb_idx_t;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input arb_idx_t idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4 -- stateless round-robin pick over 4 requesters.
// Ports:
//   req_i    [3:0] : request vector
//   rr_ptr_i [1:0] : highest-priority index for this pick
//   idx_o    [1:0] : first set request at or after rr_ptr_i, modulo 4
//   any_o          : at least one request is set (idx_o valid)
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  arb_idx_t           rr_ptr_i,
    output arb_idx_t           idx_o,
    output logic               any_o
);

    arb_idx_t cand;

    // Walk the offsets from farthest to nearest so the nearest set bit
    // (lowest offset from the pointer) is the one left standing.
    always_comb begin
        idx_o = rr_ptr_i;
        cand  = rr_ptr_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr_i + arb_idx_t'(k);  // 2-bit add wraps modulo 4
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/bus_arb4.sv
// bus_arb4 -- 4-requester round-robin bus arbiter with burst hold.
// The arbiter drives sel0/sel1 of an external 32-bit mux4_1; the mux itself
// is not part of this block.
// Optional stall watchdog compiled in with macro ARB_TIMEOUT_EN.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-high reset
//   req   [3:0]: per-requester request
//   last  [3:0]: per-requester end-of-burst, meaningful only on a beat
//   out_ready  : downstream accepts the current beat
//   gnt   [3:0]: registered one-hot grant, zero when idle
//   sel0, sel1 : registered granted index (LSB, MSB); hold while idle
//   out_valid  : request of the granted requester while busy
//   timeout    : one-cycle forced-release pulse (ARB_TIMEOUT_EN only)
module bus_arb4
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel0,
    output logic               sel1,
`ifdef ARB_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               out_valid
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("bus_arb4: TIMEOUT_CYCLES out of range 2..255");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    arb_idx_t           sel_q, sel_d;
    arb_idx_t           rr_ptr_q, rr_ptr_d;

    arb_idx_t pick_idx;
    logic     pick_any;
    logic     busy;
    logic     beat;
    logic     rel;

    rr_pick4 u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign busy = (state_q == ST_BUSY);
    // sel_q only changes on a grant, so while busy it names the owner.
    assign out_valid = busy && req[sel_q];
    assign beat      = out_valid && out_ready;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    // The pulse cycle itself forces the release on the following edge.
    assign rel = busy && (!req[sel_q] || (beat && last[sel_q]) || to_q);
`else
    assign rel = busy && (!req[sel_q] || (beat && last[sel_q]));
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    gnt_d   = idx2onehot(pick_idx);
                    sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (rel) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = sel_q + 2'd1;  // wraps modulo 4
                end
`ifdef ARB_TIMEOUT_EN
                else if (beat) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    to_d  = (cnt_q == CNT_LAST);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign sel0 = sel_q[0];
    assign sel1 = sel_q[1];
`ifdef ARB_TIMEOUT_EN
    assign timeout = to_q;
`endif

endmodule

// File: doc/bus_arb4.md
BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: number of stalled granted cycles before a forced release; legal range 2..255.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port req, input, 4: per-requester request; bit i is requester i.
REQ-005 Port last, input, 4: per-requester end-of-burst flag, qualified by the beat.
REQ-006 Port out_ready, input, 1: downstream accepts the beat on the shared 32-bit bus.
REQ-007 Port gnt, output, 4: registered one-hot grant, or zero when idle.
REQ-008 Port sel0, output, 1: LSB of the granted index; drives sel0 of the 32-bit mux4_1 that carries the payload.
REQ-009 Port sel1, output, 1: MSB of the granted index; drives sel1 of mux4_1.
REQ-010 Port out_valid, output, 1: req of the granted requester while in BUSY, else 0.
REQ-011 Port timeout, output, 1: one-cycle pulse on forced release; present only with ARB_TIMEOUT_EN.

Function
REQ-012 States SHALL be IDLE and BUSY.
REQ-013 In IDLE with req != 0, the next edge SHALL enter BUSY and grant the first set req bit at or after rr_ptr, searching upward modulo 4.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-015 gnt, sel0 and sel1 SHALL be registered and SHALL change only on state transitions, never within a burst.
REQ-016 A beat SHALL occur on any cycle in BUSY with out_valid && out_ready.
REQ-017 A beat with last[g] = 1 SHALL release: next state IDLE, gnt = 0, rr_ptr = (g+1) mod 4.
REQ-018 A beat with last[g] = 0 SHALL hold the grant.
REQ-019 If req[g] = 0 while in BUSY (abort), the block SHALL release on the next edge exactly as in REQ-017.
REQ-020 Each release SHALL cost exactly one IDLE cycle; grant latency from IDLE SHALL be one cycle.
REQ-021 In IDLE, sel0/sel1 SHALL hold their last value.
REQ-022 last bits of non-granted requesters, and last without a beat, SHALL be ignored.
REQ-023 With all four requesters continuously requesting single-beat bursts, the grant order SHALL be 0,1,2,3,0 starting from reset.

Reset
REQ-024 While reset = 1 at an edge, the block SHALL set state IDLE, gnt = 0, sel0 = 0, sel1 = 0, out_valid = 0, rr_ptr = 0, stall counter = 0, timeout = 0.
REQ-025 Reset mid-burst SHALL abandon the burst without a timeout pulse; arbitration SHALL restart from requester 0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN SHALL compile in the stall watchdog.
REQ-027 With ARB_TIMEOUT_EN defined:
- A stall counter SHALL clear on grant and on every beat.
- It SHALL increment on each BUSY cycle without a beat.
- On reaching TIMEOUT_CYCLES, the block SHALL release as in REQ-017 and pulse timeout for one cycle.
REQ-028 Without ARB_TIMEOUT_EN, the counter and the timeout port SHALL be absent, and a granted requester SHALL hold the bus indefinitely.

Structure
REQ-029 Shared package arb_pkg SHALL hold NUM_REQ = 4, the IDLE/BUSY state encoding and the 2-bit index type.
REQ-030 Sub-module rr_pick4 SHALL implement the combinational round-robin pick (req, rr_ptr -> index, any), with no state.
REQ-031 bus_arb4 SHALL NOT instantiate mux4_1; integration SHALL wire sel0/sel1 to it externally.

Verification
REQ-032 Reset, then req = 4'b0100 with out_ready = 1 and last[2] = 1 at the first beat -> gnt = 4'b0100, sel1 = 1, sel0 = 0 one cycle after req; IDLE the cycle after the beat; rr_ptr = 3.
REQ-033 req = 4'b1111 held, every beat with last -> gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-034 Requester 1 bursts 3 beats (last on the third) while req = 4'b0011, out_ready toggling 1,0,1,0,1 -> gnt stays 0010 through 3 beats; next grant goes to requester 0.
REQ-035 Requester 3 granted, deasserts req before last -> gnt = 0 on the next edge; rr_ptr = 0.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, requester 0 granted, out_ready = 0 -> timeout pulses exactly once, 4 cycles after grant; gnt = 0 on the next edge.
REQ-037 Reset asserted during the second beat of a burst -> all outputs match REQ-024 on the next edge; no timeout pulse.
